shooter_engine: RTL
===================

// Module: shooter_engine
// PURPOSE
//  Parametrised gameplay core for the shooter scene: frame-tick generation, player and
//  bullet motion, N independently moving enemy ships, hit detection and BCD score keeping.
//  Sits between vga (x, y) and the sprite/numbers/text renderers; outputs are positions,
//  colours and score digits only, no pixels. Successor to the single-enemy top-level logic.
// PARAMETERS
//  N_ENEMY      3      number of enemy ships (1..8)
//  SCORE_DIGITS 2      BCD digits per counter (1..4)
//  FLY_SPEED    1      enemy step per tick, pixels
//  PLANE_SPEED  1      player step per tick, pixels
//  BULLET_SPEED 3      bullet step per tick, pixels
//  ENEMY_X0     10'd40 enemy 0 reset x; enemy i at ENEMY_X0 + i*ENEMY_GAP
//  ENEMY_GAP    10'd160 reset spacing between enemies
//  X_MIN/X_MAX  6/600  enemy reversal bounds;  PLAYER_XMAX 608;  PLAYER_Y 440;  BULLET_YMIN 20
// PORTS
//  clk          in   1             system clock; single clock domain
//  rst          in   1             synchronous, active-high reset
//  x, y         in   10 each       current pixel coordinates from vga
//  key_left/key_right/key_fire in 1 buttons, active-low, already synchronised
//  enemy_pix    in   N_ENEMY       per-enemy sprite coverage (r|g|b) at (x,y)
//  bullet_pix   in   1             bullet sprite coverage at (x,y)
//  tik          out  1             one-clk frame tick
//  player_x     out  10            player sprite x
//  bullet_x/bullet_y out 10 each   bullet sprite position;  bullet_act out 1 bullet in flight
//  enemy_x      out  10*N_ENEMY    packed enemy x, enemy i at [10*i +: 10]
//  enemy_col    out  3*N_ENEMY     packed enemy colour {r,g,b}
//  shot_bcd/hit_bcd out 4*SCORE_DIGITS shots fired / hits scored, BCD, digit 0 = LSD
// BEHAVIOUR
//  - Reset: tik 0, player_x 320, bullet_act 0, bullet at (player_x+12, PLAYER_Y),
//    enemy_x[i]=ENEMY_X0+i*ENEMY_GAP, dir even i right / odd i left, enemy_col 3'b101,
//    counters 0, hit latches 0, fire_armed 1. rst mid-frame restores all in next cycle.
//  - tik: registered compare (x==640 && y==480); tik = compare & ~compare_q -> exactly one
//    clk pulse per frame however long the compare holds. All state below updates only on tik.
//  - Enemy i: x += / -= FLY_SPEED by dir; dir<=left when x>X_MAX, right when x<X_MIN,
//    evaluated on pre-move x (reversal one tick after crossing). Unsigned 10-bit, no wrap.
//  - Player: ~key_left & x>1 -> x-PLANE_SPEED; ~key_right & x<PLAYER_XMAX -> x+PLANE_SPEED;
//    both pressed -> no move.
//  - Hit latch hit_l[i]: set when enemy_pix[i] & bullet_pix & bullet_act & enemy_col[i]!=0;
//    cleared on tik (tik wins over set in same cycle).
//  - Bullet FSM IDLE/FLY. IDLE: bullet tracks (player_x+12, PLAYER_Y).
//    IDLE & ~key_fire & fire_armed on tik -> FLY, shot_bcd+1, fire_armed<=0.
//    fire_armed<=1 on any tik with key_fire high (no autofire: release required).
//    FLY on tik: if |hit_l -> IDLE, lowest-index hit enemy scores; elif bullet_y<BULLET_YMIN
//    -> IDLE; else bullet_y -= BULLET_SPEED. Multiple hits same frame score once.
//  - Score: scored enemy colour +1, 3'b111 -> 3'b001 (never black); hit_bcd+1.
//  - BCD counters: digit 9 -> 0 with carry; all-nines saturates (no wrap).
// STRUCTURE
//  - shooter_pkg: typedef logic [2:0] color_t; H_ACTIVE=640, V_ACTIVE=480,
//    BULLET_OFS=12, PLAYER_X0=320, ENEMY_COL0=3'b101.
//  - Sub-module bcd_counter #(DIGITS): clk, rst, inc -> q; saturating; used twice.
//  - Enemy motion and hit latches as generate loop over N_ENEMY; one FSM for bullet.
// TESTING
//  - Drive x/y raster; hold x=640,y=480 for 5 clks -> tik high exactly 1 clk per frame.
//  - Hold key_fire low 10 frames -> one shot, shot_bcd=01; release 1 frame, press -> 02.
//  - Enemy 0 at 598 moving right -> 599,600,601, then 600 (reversed); X_MIN mirror check.
//  - Bullet flying, pulse enemy_pix[1] & enemy_pix[2] with bullet_pix -> next tik
//    bullet_act=0, hit_bcd +1, only enemy_col[1] 101->110; col 111 -> 001.
//  - Preload 99 shots (SCORE_DIGITS=2), fire again -> stays 99; 09 -> 10 BCD carry.
//  - Assert rst while bullet in flight -> next clk all reset values, FSM IDLE.

Source files
------------

// File: rtl/shooter_pkg.sv
// shooter_pkg: shared types, screen constants and colour step for the shooter engine
package shooter_pkg;
  typedef logic [2:0] color_t;
  typedef enum logic {B_IDLE, B_FLY} bstate_t;
  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] BULLET_OFS = 10'd12;
  localparam logic [9:0] PLAYER_X0 = 10'd320;
  localparam color_t ENEMY_COL0 = 3'b101;
  function automatic color_t next_col(color_t c);
    return c == 3'b111 ? 3'b001 : c + 3'd1;
  endfunction
endpackage

// File: rtl/bcd_counter.sv
// bcd_counter: saturating multi-digit BCD up-counter, digit 0 is least significant
module bcd_counter #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  output logic [4*DIGITS-1:0] q
);
  logic [4*DIGITS-1:0] nq;
  logic                all9;
  always_comb begin
    nq = q;
    all9 = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      nq[4*i +: 4] = all9 ? (q[4*i +: 4] == 4'd9 ? 4'd0 : q[4*i +: 4] + 4'd1) : q[4*i +: 4];
      all9 = all9 & (q[4*i +: 4] == 4'd9);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else if (inc && !all9) q <= nq;
  end
endmodule

// File: rtl/shooter_engine.sv
// shooter_engine: frame tick, player/bullet/enemy motion, hit detection and BCD scoring
module shooter_engine
  import shooter_pkg::*;
#(
  parameter int         N_ENEMY      = 3,
  parameter int         SCORE_DIGITS = 2,
  parameter logic [9:0] FLY_SPEED    = 10'd1,
  parameter logic [9:0] PLANE_SPEED  = 10'd1,
  parameter logic [9:0] BULLET_SPEED = 10'd3,
  parameter logic [9:0] ENEMY_X0     = 10'd40,
  parameter logic [9:0] ENEMY_GAP    = 10'd160,
  parameter logic [9:0] X_MIN        = 10'd6,
  parameter logic [9:0] X_MAX        = 10'd600,
  parameter logic [9:0] PLAYER_XMAX  = 10'd608,
  parameter logic [9:0] PLAYER_Y     = 10'd440,
  parameter logic [9:0] BULLET_YMIN  = 10'd20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [9:0]                x,
  input  logic [9:0]                y,
  input  logic                      key_left,
  input  logic                      key_right,
  input  logic                      key_fire,
  input  logic [N_ENEMY-1:0]        enemy_pix,
  input  logic                      bullet_pix,
  output logic                      tik,
  output logic [9:0]                player_x,
  output logic [9:0]                bullet_x,
  output logic [9:0]                bullet_y,
  output logic                      bullet_act,
  output logic [10*N_ENEMY-1:0]     enemy_x,
  output logic [3*N_ENEMY-1:0]      enemy_col,
  output logic [4*SCORE_DIGITS-1:0] shot_bcd,
  output logic [4*SCORE_DIGITS-1:0] hit_bcd
);
  logic               cmp, cmp_q, fire_armed, fire, do_score;
  logic [9:0]         player_nx;
  logic [N_ENEMY-1:0] hit_l, low_hit;
  bstate_t            state, state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp <= 1'b0;
      cmp_q <= 1'b0;
    end else begin
      cmp <= x == H_ACTIVE && y == V_ACTIVE;
      cmp_q <= cmp;
    end
  end
  assign tik = cmp & ~cmp_q;
  always_comb
    player_nx = (~key_left & key_right & player_x > 10'd1) ? player_x - PLANE_SPEED :
                (~key_right & key_left & player_x < PLAYER_XMAX) ? player_x + PLANE_SPEED : player_x;
  always_ff @(posedge clk) begin
    if (rst) player_x <= PLAYER_X0;
    else if (tik) player_x <= player_nx;
  end
  // only the lowest-index latched hit scores when the bullet comes back
  assign low_hit = hit_l & (-hit_l);
  for (genvar i = 0; i < N_ENEMY; i++) begin : g_enemy
    logic [9:0] ex;
    logic       d, nd, h;
    color_t     c;
    assign nd = ex > X_MAX ? 1'b0 : ex < X_MIN ? 1'b1 : d;
    always_ff @(posedge clk) begin
      if (rst) begin
        ex <= ENEMY_X0 + 10'(i) * ENEMY_GAP;
        d <= (i % 2) == 0;
        h <= 1'b0;
        c <= ENEMY_COL0;
      end else begin
        if (tik) begin
          ex <= nd ? ex + FLY_SPEED : ex - FLY_SPEED;
          d <= nd;
        end
        h <= tik ? 1'b0 : h | (enemy_pix[i] & bullet_pix & bullet_act & |c);
        if (do_score && low_hit[i]) c <= next_col(c);
      end
    end
    assign enemy_x[10*i +: 10] = ex;
    assign enemy_col[3*i +: 3] = c;
    assign hit_l[i] = h;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= B_IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (tik)
      state_n = state == B_IDLE ? (~key_fire & fire_armed ? B_FLY : B_IDLE)
                                : (|hit_l || bullet_y < BULLET_YMIN ? B_IDLE : B_FLY);
  end
  always_comb begin
    bullet_act = state == B_FLY;
    fire = tik & state == B_IDLE & state_n == B_FLY;
    do_score = tik & state == B_FLY & |hit_l;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bullet_x <= PLAYER_X0 + BULLET_OFS;
      bullet_y <= PLAYER_Y;
      fire_armed <= 1'b1;
    end else if (tik) begin
      fire_armed <= key_fire | (fire_armed & ~fire);
      if (state_n == B_IDLE) begin
        bullet_x <= player_nx + BULLET_OFS;
        bullet_y <= PLAYER_Y;
      end else if (state == B_FLY) bullet_y <= bullet_y - BULLET_SPEED;
    end
  end
  bcd_counter #(.DIGITS(SCORE_DIGITS)) u_shot (.clk(clk), .rst(rst), .inc(fire), .q(shot_bcd));
  bcd_counter #(.DIGITS(SCORE_DIGITS)) u_hit (.clk(clk), .rst(rst), .inc(do_score), .q(hit_bcd));
endmodule
